// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register-sharing arbiter: FSM state type and
// default sizing constants used by the interface, top and sub-module.
package reg_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/reg_share_arbiter_if.sv
// Request/grant bus of the register-sharing arbiter. The master side drives
// requests and write data; the slave side returns grant, status and the
// shared register contents.
interface reg_share_arbiter_if
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]       gnt;
  logic [ID_W-1:0]          gnt_id;
  logic                     busy;
  logic                     done;
  logic [WIDTH-1:0]         q;
  logic [WIDTH-1:0]         nq;

  modport master (
    output req, wdata,
    input  gnt, gnt_id, busy, done, q, nq
  );

  modport slave (
    input  req, wdata,
    output gnt, gnt_id, busy, done, q, nq
  );

endinterface

// File: rtl/shared_reg.sv
// The shared WIDTH-bit register with load enable and complementary output.
// Reset is synchronous and has priority over the enable, so a write that is
// pending when reset arrives never lands.
module shared_reg
  import reg_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq
);

  logic [WIDTH-1:0] r_q;

  // Register update: clear on reset, load on enable, otherwise hold.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of block evaluation order.
    if (rst)     r_q <= '0;
    else if (en) r_q <= d;
  end

  assign q  = r_q;
  assign nq = ~r_q;

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter granting NUM_REQ requesters write access to one shared
// register. Each write takes IDLE (sample) -> GRANT (load) -> DONE (visible).
// Optional feature macro: REG_ARB_LOCK_EN adds a per-requester lock input that
// lets the current winner chain writes DONE -> GRANT without re-arbitrating.
module reg_share_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
`ifdef REG_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0] lock,
`endif
  reg_share_arbiter_if.slave bus
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             r_state;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    r_win_id;
  logic [WIDTH-1:0]   r_win_data;
  logic [NUM_REQ-1:0] r_gnt;
  logic               r_busy;
  logic               r_done;

  logic               w_found;
  logic [ID_W-1:0]    w_winner;
  logic [ID_W-1:0]    w_idx;
  logic               w_en;
  logic               w_relock;
  logic [WIDTH-1:0]   w_relock_data;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_nq;

  // Winner search: first set request bit upward from ptr+1, wrapping around,
  // so the previous winner is considered last.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned and no latch is inferred.
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && bus.req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

`ifdef REG_ARB_LOCK_EN
  assign w_relock      = lock[r_win_id] & bus.req[r_win_id];
  assign w_relock_data = bus.wdata[int'(r_win_id)*WIDTH +: WIDTH];
`else
  assign w_relock      = 1'b0;
  assign w_relock_data = '0;
`endif

  // Control FSM with registered grant/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= ID_W'(NUM_REQ - 1);
      r_win_id   <= '0;
      r_win_data <= '0;
      r_gnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (w_found) begin
            r_win_id   <= w_winner;
            r_win_data <= bus.wdata[int'(w_winner)*WIDTH +: WIDTH];
            r_gnt      <= NUM_REQ'(1) << w_winner;
            r_busy     <= 1'b1;
            r_state    <= GRANT;
          end else begin
            r_gnt  <= '0;
            r_busy <= 1'b0;
          end
        end
        GRANT: begin
          r_gnt   <= '0;
          r_done  <= 1'b1;
          r_busy  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_done <= 1'b0;
          if (w_relock) begin
            // Locked winner keeps the register: same id, fresh data, ptr kept.
            r_win_data <= w_relock_data;
            r_gnt      <= NUM_REQ'(1) << r_win_id;
            r_busy     <= 1'b1;
            r_state    <= GRANT;
          end else begin
            r_ptr   <= r_win_id;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign w_en = (r_state == GRANT);

  shared_reg #(.WIDTH(WIDTH)) u_shared_reg (
    .clk (clk),
    .rst (rst),
    .en  (w_en),
    .d   (r_win_data),
    .q   (w_q),
    .nq  (w_nq)
  );

  assign bus.gnt    = r_gnt;
  assign bus.gnt_id = r_win_id;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.q      = w_q;
  assign bus.nq     = w_nq;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Self-checking bench for reg_share_arbiter (NUM_REQ=4, WIDTH=8). A
// transaction-level model (rotating priority pointer, last written value)
// predicts grant, status and register contents for directed and random writes.
module tb_reg_share_arbiter;
  import reg_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef REG_ARB_LOCK_EN
  logic [N-1:0] lock = '0;
`endif

  reg_share_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  reg_share_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
`ifdef REG_ARB_LOCK_EN
    .lock (lock),
`endif
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_ptr;
  logic [7:0]  m_q;
  logic [1:0]  m_id;
  logic [29:0] got;
  logic [29:0] want;

  // Observed output snapshot: {gnt, gnt_id, busy, done, q, nq}.
  function automatic logic [29:0] obs();
    return {bus.gnt, bus.gnt_id, bus.busy, bus.done, bus.q, bus.nq};
  endfunction

  function automatic logic [29:0] expv(logic [3:0] g, logic [1:0] id,
                                       logic b, logic d, logic [7:0] qq);
    return {g, id, b, d, qq, ~qq};
  endfunction

  // Round-robin rule: the previous winner has lowest priority; scan the
  // requesters in rotated order p+1, p+2, ... and take the first asking.
  function automatic int pick(logic [3:0] r, int p);
    int order [4];
    for (int k = 0; k < 4; k++) order[k] = (p + 1 + k) % 4;
    foreach (order[k]) if (r[order[k]]) return order[k];
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wd(int i, logic [7:0] v);
    bus.wdata[i*W +: W] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    tick();
    rst = 1'b0;
    m_ptr = 3;
    m_q = 8'h00;
    m_id = 2'd0;
  endtask

  task automatic test_reset();
    bus.wdata = '0;
    do_reset();
    tick();
    got = obs(); want = expv(4'b0000, 2'd0, 1'b0, 1'b0, 8'h00);
    n_tests++; if (got !== want) begin n_fail++; $display("FAIL reset: got %h want %h", got, want); end
    for (int c = 0; c < 5; c++) begin
      tick();
      got = obs(); want = expv(4'b0000, 2'd0, 1'b0, 1'b0, 8'h00);
      n_tests++; if (got !== want) begin n_fail++; $display("FAIL reset_idle%0d: got %h want %h", c, got, want); end
    end
  endtask

  task automatic test_single();
    bus.req = 4'b0100;
    set_wd(2, 8'hA5);
    tick();
    got = obs(); want = expv(4'b0100, 2'd2, 1'b1, 1'b0, m_q);
    n_tests++; if (got !== want) begin n_fail++; $display("FAIL single_gnt: got %h want %h", got, want); end
    bus.req = '0;
    tick();
    got = obs(); want = expv(4'b0000, 2'd2, 1'b1, 1'b1, 8'hA5);
    n_tests++; if (got !== want) begin n_fail++; $display("FAIL single_done: got %h want %h", got, want); end
    tick();
    got = obs(); want = expv(4'b0000, 2'd2, 1'b0, 1'b0, 8'hA5);
    n_tests++; if (got !== want) begin n_fail++; $display("FAIL single_idle: got %h want %h", got, want); end
    m_ptr = 2; m_q = 8'hA5; m_id = 2'd2;
  endtask

  task automatic test_round_robin();
    int id;
    do_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) set_wd(i, 8'h10 + 8'(i));
    for (int g = 0; g < 5; g++) begin
      id = pick(4'b1111, m_ptr);
      if (id != g % 4) $display("note: model order deviates at grant %0d", g);
      tick();
      got = obs(); want = expv(4'(1 << id), 2'(id), 1'b1, 1'b0, m_q);
      n_tests++; if (got !== want) begin n_fail++; $display("FAIL rr_gnt%0d: got %h want %h", g, got, want); end
      tick();
      got = obs(); want = expv(4'b0000, 2'(id), 1'b1, 1'b1, 8'h10 + 8'(id));
      n_tests++; if (got !== want) begin n_fail++; $display("FAIL rr_done%0d: got %h want %h", g, got, want); end
      tick();
      m_ptr = id; m_q = 8'h10 + 8'(id); m_id = 2'(id);
      got = obs(); want = expv(4'b0000, m_id, 1'b0, 1'b0, m_q);
      n_tests++; if (got !== want) begin n_fail++; $display("FAIL rr_idle%0d: got %h want %h", g, got, want); end
    end
    bus.req = '0;
    tick();
  endtask

  task automatic test_reset_in_grant();
    do_reset();
    bus.req = 4'b0010;
    set_wd(1, 8'h3C);
    set_wd(0, 8'hC3);
    tick();
    got = obs(); want = expv(4'b0010, 2'd1, 1'b1, 1'b0, 8'h00);
    n_tests++; if (got !== want) begin n_fail++; $display("FAIL rg_gnt: got %h want %h", got, want); end
    rst = 1'b1;
    bus.req = '0;
    tick();
    rst = 1'b0;
    m_ptr = 3; m_q = 8'h00; m_id = 2'd0;
    got = obs(); want = expv(4'b0000, 2'd0, 1'b0, 1'b0, 8'h00);
    n_tests++; if (got !== want) begin n_fail++; $display("FAIL rg_after_rst: got %h want %h", got, want); end
    tick();
    got = obs();
    n_tests++; if (got !== want) begin n_fail++; $display("FAIL rg_no_write: got %h want %h", got, want); end
    // With ptr back at 3, requester 0 must win over all others.
    bus.req = 4'b1111;
    tick();
    bus.req = '0;
    got = obs(); want = expv(4'b0001, 2'd0, 1'b1, 1'b0, 8'h00);
    n_tests++; if (got !== want) begin n_fail++; $display("FAIL rg_ptr: got %h want %h", got, want); end
    tick();
    got = obs(); want = expv(4'b0000, 2'd0, 1'b1, 1'b1, 8'hC3);
    n_tests++; if (got !== want) begin n_fail++; $display("FAIL rg_done: got %h want %h", got, want); end
    tick();
    m_ptr = 0; m_q = 8'hC3; m_id = 2'd0;
  endtask

  task automatic test_drop();
    bus.req = 4'b0010;
    set_wd(1, 8'h77);
    tick();
    got = obs(); want = expv(4'b0010, 2'd1, 1'b1, 1'b0, m_q);
    n_tests++; if (got !== want) begin n_fail++; $display("FAIL drop_gnt: got %h want %h", got, want); end
    bus.req = '0;
    set_wd(1, 8'h00);
    tick();
    got = obs(); want = expv(4'b0000, 2'd1, 1'b1, 1'b1, 8'h77);
    n_tests++; if (got !== want) begin n_fail++; $display("FAIL drop_done: got %h want %h", got, want); end
    tick();
    got = obs(); want = expv(4'b0000, 2'd1, 1'b0, 1'b0, 8'h77);
    n_tests++; if (got !== want) begin n_fail++; $display("FAIL drop_hold: got %h want %h", got, want); end
    m_ptr = 1; m_q = 8'h77; m_id = 2'd1;
  endtask

  task automatic test_late_request();
    bus.req = 4'b0001;
    set_wd(0, 8'h5E);
    tick();
    got = obs(); want = expv(4'b0001, 2'd0, 1'b1, 1'b0, m_q);
    n_tests++; if (got !== want) begin n_fail++; $display("FAIL late_first: got %h want %h", got, want); end
    bus.req = 4'b1000;
    set_wd(3, 8'h99);
    tick();
    got = obs(); want = expv(4'b0000, 2'd0, 1'b1, 1'b1, 8'h5E);
    n_tests++; if (got !== want) begin n_fail++; $display("FAIL late_done: got %h want %h", got, want); end
    tick();
    got = obs(); want = expv(4'b0000, 2'd0, 1'b0, 1'b0, 8'h5E);
    n_tests++; if (got !== want) begin n_fail++; $display("FAIL late_idle: got %h want %h", got, want); end
    tick();
    bus.req = '0;
    got = obs(); want = expv(4'b1000, 2'd3, 1'b1, 1'b0, 8'h5E);
    n_tests++; if (got !== want) begin n_fail++; $display("FAIL late_gnt: got %h want %h", got, want); end
    tick();
    got = obs(); want = expv(4'b0000, 2'd3, 1'b1, 1'b1, 8'h99);
    n_tests++; if (got !== want) begin n_fail++; $display("FAIL late_done2: got %h want %h", got, want); end
    tick();
    m_ptr = 3; m_q = 8'h99; m_id = 2'd3;
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic [7:0] d;
    int         id;
    for (int t = 0; t < 40; t++) begin
      r = 4'($urandom_range(0, 15));
      bus.req = r;
      bus.wdata = $urandom;
      if (r == 4'b0000) begin
        tick();
        got = obs(); want = expv(4'b0000, m_id, 1'b0, 1'b0, m_q);
        n_tests++; if (got !== want) begin n_fail++; $display("FAIL rand_idle%0d: got %h want %h", t, got, want); end
      end else begin
        id = pick(r, m_ptr);
        d = bus.wdata[id*W +: W];
        tick();
        got = obs(); want = expv(4'(1 << id), 2'(id), 1'b1, 1'b0, m_q);
        n_tests++; if (got !== want) begin n_fail++; $display("FAIL rand_gnt%0d: got %h want %h", t, got, want); end
        bus.req = 4'($urandom);
        bus.wdata = $urandom;
        tick();
        got = obs(); want = expv(4'b0000, 2'(id), 1'b1, 1'b1, d);
        n_tests++; if (got !== want) begin n_fail++; $display("FAIL rand_done%0d: got %h want %h", t, got, want); end
        tick();
        m_ptr = id; m_q = d; m_id = 2'(id);
        got = obs(); want = expv(4'b0000, m_id, 1'b0, 1'b0, m_q);
        n_tests++; if (got !== want) begin n_fail++; $display("FAIL rand_ret%0d: got %h want %h", t, got, want); end
      end
    end
    bus.req = '0;
    tick();
  endtask

`ifdef REG_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    lock = 4'b0001;
    bus.req = 4'b0011;
    set_wd(0, 8'h40);
    set_wd(1, 8'h41);
    tick();
    got = obs(); want = expv(4'b0001, 2'd0, 1'b1, 1'b0, 8'h00);
    n_tests++; if (got !== want) begin n_fail++; $display("FAIL lock_gnt0: got %h want %h", got, want); end
    for (int k = 0; k < 3; k++) begin
      tick();
      got = obs(); want = expv(4'b0000, 2'd0, 1'b1, 1'b1, 8'h40 + 8'(k));
      n_tests++; if (got !== want) begin n_fail++; $display("FAIL lock_done%0d: got %h want %h", k, got, want); end
      set_wd(0, 8'h41 + 8'(k));
      if (k == 2) lock = '0;
      tick();
      if (k < 2) want = expv(4'b0001, 2'd0, 1'b1, 1'b0, 8'h40 + 8'(k));
      else       want = expv(4'b0000, 2'd0, 1'b0, 1'b0, 8'h42);
      got = obs();
      n_tests++; if (got !== want) begin n_fail++; $display("FAIL lock_next%0d: got %h want %h", k, got, want); end
    end
    tick();
    bus.req = '0;
    got = obs(); want = expv(4'b0010, 2'd1, 1'b1, 1'b0, 8'h42);
    n_tests++; if (got !== want) begin n_fail++; $display("FAIL lock_release: got %h want %h", got, want); end
    tick();
    tick();
    m_ptr = 1; m_q = 8'h41; m_id = 2'd1;
  endtask
`endif

  initial begin
    bus.req = '0;
    bus.wdata = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_reset_in_grant();
    test_drop();
    test_late_request();
    test_random();
`ifdef REG_ARB_LOCK_EN
    test_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
